vpu_bram_line_reader: RTL and testbench
=======================================

// Module: vpu_bram_line_reader
// PURPOSE
//  Streams a contiguous run of words out of the VPU's true-dual-port BRAM (one read port) as a
//  valid/ready pixel/tile stream for the downstream VPU render stage. Owns the BRAM port's
//  en/addr, absorbs the 1-cycle registered read latency, and honours backpressure without
//  losing or duplicating words. One burst per start pulse; done pulse on completion.
// PARAMETERS
//  ADDR_W  8   BRAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  8   BRAM / stream data width
//  LEN_W   9   burst length width; max burst = 2**LEN_W-1 words
// PORTS
//  clk        in   1       single clock (BRAM port clock tied to same clk)
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin burst; sampled only in IDLE
//  base_addr  in   ADDR_W  first BRAM address of burst, captured on accepted start
//  length     in   LEN_W   words in burst, captured on accepted start
//  busy       out  1       high from accepted start until done pulse inclusive
//  done       out  1       1-cycle pulse: burst finished
//  mem_en     out  1       BRAM port enable (read strobe); BRAM write enable tied 0 externally
//  mem_addr   out  ADDR_W  BRAM port address
//  mem_rdata  in   DATA_W  BRAM port dout, valid the cycle after mem_en=1
//  out_valid  out  1       stream word valid
//  out_ready  in   1       downstream accepts word when out_valid&out_ready
//  out_data   out  DATA_W  stream word
//  out_last   out  1       high with final word of burst
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; busy,done,mem_en,out_valid,out_last=0; mem_addr,
//   out_data=0; FIFO empty; inflight=0. Reset mid-burst aborts; read data returning after the
//   reset edge is discarded; no done pulse for aborted burst.
//  FSM: IDLE -> RUN on start (length!=0); IDLE -> DONE on start with length==0 (no reads, no
//   beats). RUN -> DRAIN when last read issued. DRAIN -> DONE when last beat handshaken.
//   DONE -> IDLE unconditionally (done=1 for this single cycle). start outside IDLE ignored.
//  Read issue (RUN only): mem_en=1 iff remaining>0 and (fifo_count+inflight-pop) < 2,
//   pop = out_valid&out_ready this cycle. Each issue: mem_addr=next addr, addr+1 (wraps
//   2**ADDR_W-1 -> 0), remaining-1. inflight = registered mem_en.
//  Output FIFO: 2 entries, written at end of cycle where inflight=1 with mem_rdata; out_* driven
//   from head entry (registered). Simultaneous push and pop allowed at any occupancy.
//   Never overflows by construction; underflow impossible (out_valid=fifo non-empty).
//  out_last: set on the entry carrying the length-th word; exactly one per burst.
//  out_data/out_last held stable while out_valid&!out_ready (AXI-style: valid never drops
//   without handshake).
//  Latency: start accepted at edge T -> first mem_en in cycle T+1 -> first out_valid in T+3.
//   With out_ready held 1: sustained 1 word/cycle; burst of N ends with out_last in cycle
//   T+N+2, done in T+N+3, busy low from T+N+4.
//  busy=1 in RUN, DRAIN, DONE; 0 in IDLE.
// TESTING
//  1 base=0x10,len=4, ready=1, BRAM[i]=i -> mem_en cycles T+1..T+4 addr 10..13; out 10,11,12,13
//    in T+3..T+6, out_last only on 13; done one cycle at T+7.
//  2 base=0xFE,len=4 (ADDR_W=8) -> addresses FE,FF,00,01 in order; data matches BRAM contents.
//  3 len=8, out_ready toggles 1,0,0,1,... random -> all 8 words once, in order, data stable
//    during stalls, mem_en never issued with FIFO+inflight full.
//  4 len=0 -> no mem_en, no out_valid; busy 1 for 1 cycle (DONE), done pulse T+1.
//  5 start pulsed again mid-burst with other base/len -> ignored; original burst completes intact.
//  6 rst=1 for 1 cycle mid-burst (after 3 of 8 words) -> next cycle all outputs at reset
//    values, no further beats/done; fresh start then runs correctly from new base.

Source files
------------

// File: rtl/vpu_bram_line_reader.sv
// Burst reader for one BRAM read port: issues reads for a contiguous address run and
// re-times the 1-cycle read latency into a valid/ready stream through a 2-entry skid FIFO.
module vpu_bram_line_reader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic              inflight_last;

    // Second FIFO slot; the head slot is the out_* register set itself.
    logic              t_valid;
    logic              t_last;
    logic [DATA_W-1:0] t_data;

    logic              pop;
    logic              issue_last;
    logic [1:0]        occ;

    logic              h_valid_n;
    logic              h_last_n;
    logic [DATA_W-1:0] h_data_n;
    logic              t_valid_n;
    logic              t_last_n;
    logic [DATA_W-1:0] t_data_n;

    assign pop = out_valid & out_ready;

    // Read issue: only when the word can be guaranteed a FIFO slot on return.
    always_comb begin
        occ        = 2'(out_valid) + 2'(t_valid) + 2'(inflight) - 2'(pop);
        mem_en     = (state == RUN) && (remaining != '0) && (occ < 2'd2);
        issue_last = mem_en && (remaining == LEN_W'(1));
    end

    // FIFO next state: pop shifts tail into head, then returning data fills the first free slot.
    always_comb begin
        h_valid_n = out_valid;
        h_data_n  = out_data;
        h_last_n  = out_last;
        t_valid_n = t_valid;
        t_data_n  = t_data;
        t_last_n  = t_last;
        if (pop) begin
            h_valid_n = t_valid;
            h_data_n  = t_data;
            h_last_n  = t_last;
            t_valid_n = 1'b0;
        end
        if (inflight) begin
            if (!h_valid_n) begin
                h_valid_n = 1'b1;
                h_data_n  = mem_rdata;
                h_last_n  = inflight_last;
            end else begin
                t_valid_n = 1'b1;
                t_data_n  = mem_rdata;
                t_last_n  = inflight_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            t_valid       <= 1'b0;
            t_data        <= '0;
            t_last        <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= mem_en;
            inflight_last <= issue_last;
            out_valid     <= h_valid_n;
            out_data      <= h_data_n;
            out_last      <= h_last_n;
            t_valid       <= t_valid_n;
            t_data        <= t_data_n;
            t_last        <= t_last_n;

            if (mem_en) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_bram_line_reader.sv
// Directed bench for vpu_bram_line_reader with a 1-cycle-latency BRAM model (BRAM[i] = i).
module tb_vpu_bram_line_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic       mem_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    vpu_bram_line_reader #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Runs from cycle T+1 of a burst until done, checking addresses, beats, stalls and occupancy.
    task automatic collect(input string tag, input logic [7:0] b, input int n, input logic [15:0] rpat);
        int         got    = 0;
        int         issued = 0;
        bit         seen_done = 1'b0;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = '0;
        logic [7:0] exp_addr = b;
        logic [7:0] exp_data;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (c == 1) start = 1'b0;
            out_ready = rpat[c % 16];
            #1;
            if (mem_en) begin
                chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
                exp_addr = exp_addr + 8'd1;
                issued++;
                chk({tag, "_occ"}, 32'((issued - got - int'(out_valid & out_ready)) <= 2), 32'd1);
            end
            if (pv && !pr) begin
                chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_d"}, 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                exp_data = b + 8'(got);
                chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
                chk({tag, "_last"}, 32'(out_last), 32'(got == n - 1));
                got++;
            end
            if (done) seen_done = 1'b1;
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            step();
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_beats"}, 32'(got), 32'(n));
        chk({tag, "_reads"}, 32'(issued), 32'(n));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: cycle-exact burst, base 0x10 len 4, ready held high
        start_burst(8'h10, 9'd4);
        chk("t1_c1_en", 32'(mem_en), 32'd1);
        chk("t1_c1_addr", 32'(mem_addr), 32'h10);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_c2_en", 32'(mem_en), 32'd1);
        chk("t1_c2_addr", 32'(mem_addr), 32'h11);
        chk("t1_c2_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_c3_addr", 32'(mem_addr), 32'h12);
        chk("t1_c3_valid", 32'(out_valid), 32'd1);
        chk("t1_c3_data", 32'(out_data), 32'h10);
        chk("t1_c3_last", 32'(out_last), 32'd0);
        step();
        chk("t1_c4_en", 32'(mem_en), 32'd1);
        chk("t1_c4_addr", 32'(mem_addr), 32'h13);
        chk("t1_c4_data", 32'(out_data), 32'h11);
        step();
        chk("t1_c5_en", 32'(mem_en), 32'd0);
        chk("t1_c5_data", 32'(out_data), 32'h12);
        chk("t1_c5_last", 32'(out_last), 32'd0);
        step();
        chk("t1_c6_valid", 32'(out_valid), 32'd1);
        chk("t1_c6_data", 32'(out_data), 32'h13);
        chk("t1_c6_last", 32'(out_last), 32'd1);
        chk("t1_c6_done", 32'(done), 32'd0);
        step();
        chk("t1_c7_done", 32'(done), 32'd1);
        chk("t1_c7_busy", 32'(busy), 32'd1);
        chk("t1_c7_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_c8_done", 32'(done), 32'd0);
        chk("t1_c8_busy", 32'(busy), 32'd0);

        // Test 2: address wrap FE,FF,00,01
        start_burst(8'hFE, 9'd4);
        collect("t2", 8'hFE, 4, 16'hFFFF);

        // Test 3: backpressure, ready pattern starts 1,0,0,1
        start_burst(8'h40, 9'd8);
        collect("t3", 8'h40, 8, 16'b1011_0110_0101_1001);

        // Test 4: zero-length burst
        out_ready = 1'b1;
        start_burst(8'h70, 9'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_en", 32'(mem_en), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        step();
        chk("t4_busy_lo", 32'(busy), 32'd0);
        chk("t4_done_lo", 32'(done), 32'd0);
        chk("t4_en_lo", 32'(mem_en), 32'd0);
        chk("t4_valid_lo", 32'(out_valid), 32'd0);

        // Test 5: second start mid-burst is ignored
        start_burst(8'h20, 9'd3);
        base_addr = 8'h80;
        length    = 9'd5;
        start     = 1'b1;
        collect("t5", 8'h20, 3, 16'hFFFF);
        step();
        chk("t5_no_restart_en", 32'(mem_en), 32'd0);
        chk("t5_no_restart_busy", 32'(busy), 32'd0);

        // Test 6: reset after three beats accepted
        out_ready = 1'b1;
        start_burst(8'h30, 9'd8);
        step();
        step();
        chk("t6_b0", 32'(out_data), 32'h30);
        step();
        chk("t6_b1", 32'(out_data), 32'h31);
        step();
        chk("t6_b2", 32'(out_data), 32'h32);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_en", 32'(mem_en), 32'd0);
        chk("t6_rst_addr", 32'(mem_addr), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_last", 32'(out_last), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_quiet_valid", 32'(out_valid), 32'd0);
            chk("t6_quiet_done", 32'(done), 32'd0);
        end
        start_burst(8'h50, 9'd3);
        collect("t6_fresh", 8'h50, 3, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
